axi4_lite_arbiter: RTL
======================

AXI4_LITE_ARBITER -- requirements
Module: axi4_lite_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 4, address width of requester and master ports.
REQ-002 Parameter: DATA_W, default 32, data width of write/read data.
REQ-003 Clocking is decided: one clock; reset is asynchronous and active-low.
REQ-004 Port: ACLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port: ARESETn  input  1  asynchronous active-low reset.
REQ-006 Port: req  input  2  per-requester request, level, held until matching ack.
REQ-007 Port: req_write  input  2  per-requester direction; 1=write, 0=read.
REQ-008 Port: req_addr0 / req_addr1  input  ADDR_W each  requester address.
REQ-009 Port: req_wdata0 / req_wdata1  input  DATA_W each  requester write data.
REQ-010 Port: ack  output  2  one-cycle completion pulse per requester.
REQ-011 Port: rdata  output  DATA_W  registered read data, valid in the ack cycle.
REQ-012 Port: grant_id  output  1  index of the currently owning requester.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: m_addr / m_write / m_wdata  output  ADDR_W/1/DATA_W  command to the AXI4-Lite master internal port.
REQ-015 Port: m_transfer  output  1  one-cycle command strobe to the master.
REQ-016 Port: m_rdata  input  DATA_W  master read data, valid while m_ready is high.
REQ-017 Port: m_ready  input  1  master completion pulse, write or read.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, ACK; at most one transaction is outstanding.
REQ-019 IDLE: if any req bit is high, select the winner, latch its addr/write/wdata into command registers, set grant_id, and go to ISSUE; otherwise stay.
REQ-020 Arbitration is round-robin: with both requesting, grant the index != last_grant; with one requesting, grant it.
REQ-021 last_grant SHALL update to the winner at each IDLE->ISSUE transition.
REQ-022 ISSUE: m_transfer=1 for exactly one cycle with m_addr/m_write/m_wdata from the command registers; go to WAIT.
REQ-023 m_addr/m_write/m_wdata SHALL stay stable from ISSUE through ACK.
REQ-024 WAIT: on m_ready=1, capture m_rdata into rdata (reads only; rdata is unchanged on writes) and go to ACK; otherwise stay, with no timeout.
REQ-025 ACK: ack[grant_id]=1 for one cycle, the other ack bit 0; go to IDLE; req is not sampled in ACK.
REQ-026 Requesters drop req on the edge that ends their ack cycle; a new grant starts at the earliest in the IDLE cycle after ACK.
REQ-027 Throughput: 4 cycles per transaction when m_ready arrives in the first WAIT cycle.
REQ-028 m_ready seen outside WAIT SHALL be ignored.
REQ-029 Changes on req or requester data after latching SHALL NOT affect the transaction in flight.

Reset
REQ-030 ARESETn=0 SHALL force IDLE immediately, regardless of clock.
REQ-031 Reset values: ack=0, m_transfer=0, busy=0, rdata=0, m_addr=0, m_write=0, m_wdata=0, grant_id=0, last_grant=1, so requester 0 wins first.
REQ-032 Reset mid-transaction SHALL abandon it without an ack; the master is reset by the same ARESETn.

Verification
REQ-033 Single write: req=01, req_write0=1, addr0=0x4, wdata0=0xDEADBEEF -> one m_transfer with m_addr=0x4, m_write=1, m_wdata=0xDEADBEEF; m_ready after 3 cycles -> ack=01 one cycle, rdata unchanged.
REQ-034 Single read: req=10, addr1=0x8, m_ready with m_rdata=0x12345678 -> rdata=0x12345678 with ack=10; grant_id=1 throughout.
REQ-035 Contention: req=11 from reset -> grants in order 0,1,0,1 over four back-to-back transactions; exactly one m_transfer per grant.
REQ-036 Stability: change req_addr0 and req_wdata0 during WAIT -> m_addr and m_wdata unchanged until ACK.
REQ-037 Spurious ready: m_ready=1 in IDLE and in ISSUE -> no ack and no state change.
REQ-038 Reset in WAIT: ARESETn low mid-WAIT -> busy=0 and all outputs at reset values at once; no ack; first grant after release goes to requester 0.

Source files
------------

// File: rtl/axi4_lite_arbiter.sv
`default_nettype none
// =============================================================================
// axi4_lite_arbiter : round-robin arbiter feeding two requesters into a single
//                     AXI4-Lite master command port, one transaction in flight
// Revision: 1.0
// =============================================================================
module axi4_lite_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic [1:0]        req,
   input  logic [1:0]        req_write,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic [1:0]        ack,
   output logic [DATA_W-1:0] rdata,
   output logic              grant_id,
   output logic              busy,
   output logic [ADDR_W-1:0] m_addr,
   output logic              m_write,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_transfer,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_last_grant;
   logic                r_grant_id;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_write;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic                w_win;
   logic                w_latch;
   logic [1:0]          w_ack;

   // Under contention the requester that did not win last time gets the bus.
   assign w_win   = (req == 2'b11) ? ~r_last_grant : req[1];
   assign w_latch = (r_state == ST_IDLE) && (|req);

   always_comb begin
      w_next = r_state;
      w_ack  = 2'b00;
      case (r_state)
         ST_IDLE:  if (|req) w_next = ST_ISSUE;
         ST_ISSUE: w_next = ST_WAIT;
         ST_WAIT:  if (m_ready) w_next = ST_ACK;
         ST_ACK: begin
            w_next            = ST_IDLE;
            w_ack[r_grant_id] = 1'b1;
         end
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_grant_id   <= 1'b0;
         r_addr       <= '0;
         r_write      <= 1'b0;
         r_wdata      <= '0;
         r_rdata      <= '0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_grant_id   <= w_win;
            r_last_grant <= w_win;
            r_addr       <= w_win ? req_addr1  : req_addr0;
            r_wdata      <= w_win ? req_wdata1 : req_wdata0;
            r_write      <= req_write[w_win];
         end
         if ((r_state == ST_WAIT) && m_ready && !r_write) begin
            r_rdata <= m_rdata;
         end
      end
   end

   assign ack        = w_ack;
   assign rdata      = r_rdata;
   assign grant_id   = r_grant_id;
   assign busy       = (r_state != ST_IDLE);
   assign m_addr     = r_addr;
   assign m_write    = r_write;
   assign m_wdata    = r_wdata;
   assign m_transfer = (r_state == ST_ISSUE);

endmodule
`default_nettype wire
